// File: rtl/tart_aq_prefetch_pkg.sv
// Shared register map, status bit layout and sizing helpers for the antenna-data readback unit.
package tart_aq_prefetch_pkg;

    localparam logic [1:0] AQ_STREAM  = 2'd0;
    localparam logic [1:0] AQ_STATUS  = 2'd1;
    localparam logic [1:0] AQ_CONTROL = 2'd2;

    // Status bit offsets counted down from the bus MSB; level fills the bits below ST_LEVEL.
    localparam int unsigned ST_UNDERRUN = 0;
    localparam int unsigned ST_OVERRUN  = 1;
    localparam int unsigned ST_EMPTY    = 2;
    localparam int unsigned ST_FULL     = 3;
    localparam int unsigned ST_LEVEL    = 4;

    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_WAIT = 1'b1
    } pf_state_e;

    function automatic int unsigned nbytes(input int unsigned axnum, input int unsigned width);
        return (axnum + width - 1) / width;
    endfunction

endpackage

// File: rtl/tart_sync_fifo.sv
// Synchronous FIFO, 2^ABITS x DW, with flush and occupancy level; head is a combinational peek.
module tart_sync_fifo #(
    parameter int unsigned DW    = 24,
    parameter int unsigned ABITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  logic [DW-1:0]    din,
    input  logic             pop,
    output logic [DW-1:0]    head_c,
    output logic [ABITS:0]   level,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned DEPTH = 2 ** ABITS;

    logic [DW-1:0]    mem [DEPTH];
    logic [ABITS-1:0] rd_ptr;
    logic [ABITS-1:0] wr_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c    = (level == (ABITS+1)'(DEPTH));
    assign empty_c   = (level == '0);
    assign push_ok_c = push && !full_c;
    assign pop_ok_c  = pop && !empty_c;
    assign head_c    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok_c)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok_c, pop_ok_c})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_c && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tart_aq_prefetch.sv
// Raw antenna-data readback: prefetches samples from DRAM into a FIFO and streams them
// MSB-first over the SPI-side bus, with status/control registers and sticky error flags.
module tart_aq_prefetch
    import tart_aq_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned AXNUM   = 24,
    parameter int unsigned ABITS   = 2,
    parameter int unsigned CLASSIC = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    output logic              ack_o,
    output logic              wat_o,
    output logic              rty_o,
    output logic              err_o,
    input  logic [1:0]        adr_i,
    input  logic [WIDTH-1:0]  dat_i,
    output logic [WIDTH-1:0]  dat_o,
    output logic              data_request,
    input  logic              data_ready,
    input  logic [AXNUM-1:0]  data_in,
    input  logic              spi_busy,
    output logic              aq_enabled,
    output logic [ABITS:0]    level
);

    localparam int unsigned NBYTES = nbytes(AXNUM, WIDTH);
    localparam int unsigned PW     = NBYTES * WIDTH;
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    logic             acc_c, rd_c, wr_c;
    logic             stream_rd_c, ctrl_wr_c, stat_wr_c, flush_c;
    logic             pop_c, push_c, req_c;
    logic [AXNUM-1:0] head_c;
    logic             full_c, empty_c;
    logic [PW-1:0]    padded_c;
    logic [WIDTH-1:0] byte_c, status_c, rdata_c;
    logic [IW-1:0]    index_q;
    logic             underrun_q, overrun_q, discard_q;
    pf_state_e        state_q, state_d;
    logic             unused_c;

    assign wat_o = 1'b0;
    assign rty_o = 1'b0;
    assign err_o = 1'b0;
    assign unused_c = ^dat_i[WIDTH-3:0];

    // Classic mode refuses a strobe while the previous ack is still high.
    assign acc_c       = cyc_i && stb_i && ((CLASSIC == 0) || !ack_o);
    assign rd_c        = acc_c && !we_i;
    assign wr_c        = acc_c && we_i;
    assign stream_rd_c = rd_c && (adr_i == AQ_STREAM);
    assign ctrl_wr_c   = wr_c && (adr_i == AQ_CONTROL);
    assign stat_wr_c   = wr_c && (adr_i == AQ_STATUS);
    assign flush_c     = ctrl_wr_c && dat_i[WIDTH-2];
    assign pop_c       = stream_rd_c && !empty_c && (index_q == LAST_IDX);
    assign push_c      = data_ready && !discard_q;

    tart_sync_fifo #(
        .DW    (AXNUM),
        .ABITS (ABITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (flush_c),
        .push    (push_c),
        .din     (data_in),
        .pop     (pop_c),
        .head_c  (head_c),
        .level   (level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign padded_c = PW'(head_c);
    assign byte_c   = WIDTH'(padded_c >> (32'(LAST_IDX - index_q) * WIDTH));

    always_comb begin
        status_c = '0;
        status_c[WIDTH-1-ST_UNDERRUN] = underrun_q;
        status_c[WIDTH-1-ST_OVERRUN]  = overrun_q;
        status_c[WIDTH-1-ST_EMPTY]    = empty_c;
        status_c[WIDTH-1-ST_FULL]     = full_c;
        status_c[WIDTH-1-ST_LEVEL:0]  = (WIDTH-ST_LEVEL)'(level);
    end

    always_comb begin
        rdata_c = '0;
        unique case (adr_i)
            AQ_STREAM:  rdata_c = empty_c ? '0 : byte_c;
            AQ_STATUS:  rdata_c = status_c;
            AQ_CONTROL: rdata_c[WIDTH-1] = aq_enabled;
            default:    rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o      <= 1'b0;
            dat_o      <= '0;
            aq_enabled <= 1'b0;
        end else begin
            ack_o <= acc_c;
            if (acc_c)     dat_o      <= rd_c ? rdata_c : '0;
            if (ctrl_wr_c) aq_enabled <= dat_i[WIDTH-1];
        end
    end

    // Byte cursor into the head word; an ended SPI transaction rewinds to the MSB.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_c || !spi_busy) begin
            index_q <= '0;
        end else if (stream_rd_c && !empty_c) begin
            index_q <= (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
        end
    end

    // Sticky flags: a new event wins over a same-cycle clear so none is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (stream_rd_c && empty_c) underrun_q <= 1'b1;
            else if (stat_wr_c)         underrun_q <= 1'b0;
            if (push_c && full_c && !flush_c) overrun_q <= 1'b1;
            else if (stat_wr_c)               overrun_q <= 1'b0;
        end
    end

    // A flush while a fetch is in flight marks that fetch's data for discard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            discard_q <= 1'b0;
        end else if (data_ready) begin
            discard_q <= 1'b0;
        end else if (flush_c && (state_q == PF_WAIT)) begin
            discard_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= PF_IDLE;
            data_request <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_request <= req_c;
        end
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        unique case (state_q)
            PF_IDLE: begin
                if (aq_enabled && !full_c && !flush_c) begin
                    req_c   = 1'b1;
                    state_d = PF_WAIT;
                end
            end
            PF_WAIT: begin
                if (data_ready) state_d = PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase
    end

endmodule
